alu_result_fifo: RTL
====================

Name: alu_result_fifo

Overview:
- Downstream stage of the 8-bit ALU. Captures each ALU result (out, c_out) with the opcode (sel) that produced it.
- Derives zero/negative flags and buffers entries in a small FIFO with valid/ready handshakes on both sides.
- Decouples the combinational ALU from a slower consumer, such as a writeback or trace unit.

Parameters:
- DATA_W, 8, width of the ALU result.
- SEL_W, 3, width of the ALU opcode select.
- DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  ALU result present on alu_out/alu_c_out/alu_sel.
- in_ready  output  1  FIFO can accept an entry this cycle.
- alu_out  input  DATA_W  ALU result.
- alu_c_out  input  1  ALU carry out.
- alu_sel  input  SEL_W  opcode that produced the result.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts head entry.
- out_data  output  DATA_W  head result.
- out_carry  output  1  head carry.
- out_sel  output  SEL_W  head opcode.
- out_zero  output  1  head result == 0.
- out_neg  output  1  head result MSB.
- count  output  $clog2(DEPTH)+1  current occupancy.
- carry_cnt  output  8  accepted entries with carry set (optional feature).
- stall_cnt  output  8  backpressured cycles (optional feature).

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: pointers=0, count=0, in_ready=1, out_valid=0, stats counters=0.
  - out_data/out_carry/out_sel/out_zero/out_neg are 0 while empty after reset.
  - Storage contents are not reset.
- Push occurs when in_valid && in_ready.
  - Entry stored = {alu_sel, alu_c_out, alu_out==0, alu_out[DATA_W-1], alu_out}.
  - Flags are computed at capture, not at read.
- Pop occurs when out_valid && out_ready. The read pointer advances.
- in_ready = (count != DEPTH). It is registered-state derived and never depends combinationally on out_ready.
  - When full, a simultaneous pop does not allow a push that cycle; in_ready rises the following cycle.
- out_valid = (count != 0). Head fields are a combinational read of mem[rd_ptr].
- Latency: an entry pushed at edge N is visible with out_valid=1 immediately after edge N, i.e. one cycle of latency.
  - No fall-through: an entry pushed while empty is never poppable in the same cycle.
- Simultaneous push and pop (0<count<DEPTH): count unchanged, both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count = push ? (pop ? count : count+1) : (pop ? count-1 : count).
- Ordering is strict FIFO. No entry is dropped or duplicated.
  - Upstream must hold in_valid and its inputs stable until accepted.
- Inputs are ignored while in_valid=0. out_ready is ignored while out_valid=0.
- Asserting reset mid-operation takes effect immediately and asynchronously: count=0, out_valid=0, in_ready=1.
  - Buffered entries are lost.
  - Operation resumes on the first rising clk after rst_n deasserts.

Optional Feature:
- Macro: ALU_RESULT_FIFO_STATS_EN.
- Defined:
  - carry_cnt increments on each push with alu_c_out=1.
  - stall_cnt increments each cycle with in_valid && !in_ready.
  - Both saturate at 255 and clear only on reset.
- Undefined: both ports tie to constant 0, with no counter flops. The port list is unchanged.

Test Plan:
- Reset with rst_n=0 mid-stream (count=3) -> count=0, out_valid=0, in_ready=1 asynchronously, before the next clk edge.
- Single push alu_out=8'h09, c_out=0, sel=3'b000, out_ready=0 -> next cycle out_valid=1, out_data=8'h09, out_zero=0, out_neg=0, count=1.
- Push sel 0..7 back-to-back with alu_out=8'h00,8'h80,8'h01,... and out_ready=0:
  - After 4 pushes in_ready=0 and count=4.
  - Further entries are held by upstream; stall_cnt counts those cycles if the feature is enabled.
  - Heads 8'h00 and 8'h80 report out_zero=1 and out_neg=1 respectively.
- Full FIFO with out_ready=1 and in_valid=1 on the same cycle -> pop only, count 4->3. Push accepted the next cycle, count back to 4.
- Steady streaming with in_valid=out_ready=1 for 20 cycles and alu_out incrementing from 8'h00 -> outputs appear in order with one cycle of latency.
  - Exercises pointer wrap-around 5 times; count stays 1 after the first cycle.
- With ALU_RESULT_FIFO_STATS_EN, push 300 entries with c_out=1 -> carry_cnt saturates at 255.
  - Without the macro, carry_cnt stays 0 throughout.

Source files
------------

// File: rtl/alu_result_fifo.sv
// Result buffer behind the 8-bit ALU: captures {sel, carry, zero, neg, data} into a small FIFO.
// Optional saturating statistics counters are enabled with ALU_RESULT_FIFO_STATS_EN.
module alu_result_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        alu_out,
  input  logic                     alu_c_out,
  input  logic [SEL_W-1:0]         alu_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_carry,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               carry_cnt,
  output logic [7:0]               stall_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic              carry;
    logic              zero;
    logic              neg;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           wr_entry;
  entry_t           head;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push, pop;

  // Handshake status comes only from registered occupancy, so a full FIFO
  // cannot accept a push in the same cycle it is popped.
  assign in_ready  = (count_q != Full);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  always_comb begin
    wr_entry.sel   = alu_sel;
    wr_entry.carry = alu_c_out;
    wr_entry.zero  = (alu_out == '0);
    wr_entry.neg   = alu_out[DATA_W-1];
    wr_entry.data  = alu_out;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Head fields are masked while empty so stale storage never leaks out.
  always_comb begin
    head      = mem_q[rd_ptr_q];
    out_data  = out_valid ? head.data  : '0;
    out_carry = out_valid ? head.carry : 1'b0;
    out_sel   = out_valid ? head.sel   : '0;
    out_zero  = out_valid ? head.zero  : 1'b0;
    out_neg   = out_valid ? head.neg   : 1'b0;
  end

`ifdef ALU_RESULT_FIFO_STATS_EN
  logic [7:0] carry_cnt_q, carry_cnt_d;
  logic [7:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    carry_cnt_d = carry_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (push && alu_c_out && (carry_cnt_q != 8'hff)) begin
      carry_cnt_d = carry_cnt_q + 8'd1;
    end
    if (in_valid && !in_ready && (stall_cnt_q != 8'hff)) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      carry_cnt_q <= carry_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign carry_cnt = carry_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign carry_cnt = 8'd0;
  assign stall_cnt = 8'd0;
`endif

endmodule
